// File: rtl/reduce_tree_pipe.sv
// Pipelined bitwise AND/OR/XOR reduction tree with a valid/ready handshake on every level.
// Optional transfer counter on out_count when REDUCE_TREE_CNT_EN is defined.
module reduce_tree_pipe #(
    parameter int N_IN   = 4,
    parameter int DATA_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    input  logic [1:0]               in_op,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [1:0]               out_op,
    output logic                     out_valid,
    input  logic                     out_ready
`ifdef REDUCE_TREE_CNT_EN
    ,
    output logic [15:0]              out_count
`endif
);

    localparam int LAT = (N_IN > 2) ? $clog2(N_IN) : 1;
    localparam int NP  = 1 << LAT;

    function automatic logic [DATA_W-1:0] ident(input logic [1:0] op);
        if (op == 2'b01 || op == 2'b10)
            return '0;
        return '1;
    endfunction

    function automatic logic [DATA_W-1:0] red2(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [1:0]        op);
        case (op)
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Missing operands up to the next power of two take the op's identity value.
    logic [DATA_W-1:0] pad [NP];

    for (genvar i = 0; i < NP; i++) begin : g_pad
        if (i < N_IN) begin : g_real
            assign pad[i] = in_data[i*DATA_W +: DATA_W];
        end else begin : g_ident
            assign pad[i] = ident(in_op);
        end
    end

    logic [LAT:0]   rdy;
    logic [LAT-1:0] v;
    logic [1:0]     op_tag [LAT];

    assign rdy[LAT] = out_ready;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < LAT; k++) begin : g_stg
        localparam int W = NP >> (k + 1);

        logic [DATA_W-1:0] q [W];
        logic [DATA_W-1:0] d [W];
        logic              v_q;
        logic [1:0]        op_q;
        logic              vin;
        logic [1:0]        opin;

        if (k == 0) begin : g_first
            assign vin  = in_valid;
            assign opin = in_op;
            for (genvar j = 0; j < W; j++) begin : g_node
                assign d[j] = red2(pad[2*j], pad[2*j+1], in_op);
            end
        end else begin : g_next
            assign vin  = v[k-1];
            assign opin = op_tag[k-1];
            for (genvar j = 0; j < W; j++) begin : g_node
                assign d[j] = red2(g_stg[k-1].q[2*j], g_stg[k-1].q[2*j+1], op_tag[k-1]);
            end
        end

        // An empty stage always loads, so bubbles collapse under a downstream stall.
        assign rdy[k]    = !v_q || rdy[k+1];
        assign v[k]      = v_q;
        assign op_tag[k] = op_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                op_q <= 2'b00;
                for (int j = 0; j < W; j++)
                    q[j] <= '0;
            end else if (rdy[k]) begin
                v_q <= vin;
                if (vin) begin
                    op_q <= opin;
                    for (int j = 0; j < W; j++)
                        q[j] <= d[j];
                end
            end
        end

        if (k == LAT - 1) begin : g_last
            assign out_data = q[0];
            assign out_op   = op_q;
        end
    end

    assign out_valid = v[LAT-1];

`ifdef REDUCE_TREE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 16'd0;
        else if (out_valid && out_ready && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
    end

    assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed bench for reduce_tree_pipe: three parameterisations (4x8, 5x4, 1x8) share clock and reset.
// Counter checks run only when REDUCE_TREE_CNT_EN is defined.
module tb_reduce_tree_pipe;

    logic clk;
    logic rst_n;

    logic [31:0] a_in_data;
    logic [1:0]  a_in_op;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_op;

    logic [19:0] b_in_data;
    logic [1:0]  b_in_op;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]  b_out_data;
    logic [1:0]  b_out_op;

    logic [7:0]  c_in_data;
    logic [1:0]  c_in_op;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [7:0]  c_out_data;
    logic [1:0]  c_out_op;

`ifdef REDUCE_TREE_CNT_EN
    logic [15:0] a_out_count, b_out_count, c_out_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    reduce_tree_pipe #(.N_IN(4), .DATA_W(8)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_in_data), .in_op(a_in_op), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_op(a_out_op), .out_valid(a_out_valid), .out_ready(a_out_ready)
`ifdef REDUCE_TREE_CNT_EN
        , .out_count(a_out_count)
`endif
    );

    reduce_tree_pipe #(.N_IN(5), .DATA_W(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_in_data), .in_op(b_in_op), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_op(b_out_op), .out_valid(b_out_valid), .out_ready(b_out_ready)
`ifdef REDUCE_TREE_CNT_EN
        , .out_count(b_out_count)
`endif
    );

    reduce_tree_pipe #(.N_IN(1), .DATA_W(8)) u_c (
        .clk(clk), .rst_n(rst_n),
        .in_data(c_in_data), .in_op(c_in_op), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_op(c_out_op), .out_valid(c_out_valid), .out_ready(c_out_ready)
`ifdef REDUCE_TREE_CNT_EN
        , .out_count(c_out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_data = '0; a_in_op = 2'b00; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_op = 2'b00; b_in_valid = 1'b0; b_out_ready = 1'b1;
        c_in_data = '0; c_in_op = 2'b00; c_in_valid = 1'b0; c_out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  32'(a_out_data),  32'd0);
        chk("rst_out_op",    32'(a_out_op),    32'd0);
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        // single AND, latency 2
        a_in_data = 32'hFFF03CFF; a_in_op = 2'b00; a_in_valid = 1'b1;
        #1 chk("t1_in_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
        chk("t1_early_valid", 32'(a_out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(a_out_valid), 32'd1);
        chk("t1_data",  32'(a_out_data),  32'h30);
        chk("t1_op",    32'(a_out_op),    32'd0);
        tick();
        chk("t1_drained", 32'(a_out_valid), 32'd0);

        // AND, OR, XOR back to back
        a_in_op = 2'b00; a_in_valid = 1'b1;
        tick();
        a_in_op = 2'b01;
        tick();
        chk("t2_and_valid", 32'(a_out_valid), 32'd1);
        chk("t2_and_data",  32'(a_out_data),  32'h30);
        chk("t2_and_op",    32'(a_out_op),    32'd0);
        a_in_op = 2'b10;
        tick();
        chk("t2_or_valid", 32'(a_out_valid), 32'd1);
        chk("t2_or_data",  32'(a_out_data),  32'hFF);
        chk("t2_or_op",    32'(a_out_op),    32'd1);
        a_in_valid = 1'b0;
        tick();
        chk("t2_xor_valid", 32'(a_out_valid), 32'd1);
        chk("t2_xor_data",  32'(a_out_data),  32'hCC);
        chk("t2_xor_op",    32'(a_out_op),    32'd2);
        tick();
        chk("t2_drained", 32'(a_out_valid), 32'd0);

        // backpressure: capacity 2, third held off
        a_out_ready = 1'b0;
        a_in_op = 2'b00; a_in_valid = 1'b1;
        #1 chk("t3_rdy_1", 32'(a_in_ready), 32'd1);
        tick();
        a_in_op = 2'b01;
        #1 chk("t3_rdy_2", 32'(a_in_ready), 32'd1);
        tick();
        a_in_op = 2'b10;
        #1 chk("t3_rdy_3", 32'(a_in_ready), 32'd0);
        chk("t3_head_data", 32'(a_out_data), 32'h30);
        tick();
        tick();
        chk("t3_still_full", 32'(a_in_ready),  32'd0);
        chk("t3_held_valid", 32'(a_out_valid), 32'd1);
        chk("t3_held_data",  32'(a_out_data),  32'h30);
        chk("t3_held_op",    32'(a_out_op),    32'd0);
        a_out_ready = 1'b1;
        #1 chk("t3_rdy_release", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
        chk("t3_second_data", 32'(a_out_data), 32'hFF);
        chk("t3_second_op",   32'(a_out_op),   32'd1);
        tick();
        chk("t3_third_valid", 32'(a_out_valid), 32'd1);
        chk("t3_third_data",  32'(a_out_data),  32'hCC);
        chk("t3_third_op",    32'(a_out_op),    32'd2);
        tick();
        chk("t3_no_dup", 32'(a_out_valid), 32'd0);

        // reserved op behaves as AND with op echoed
        a_in_op = 2'b11; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        chk("t_rsv_data", 32'(a_out_data), 32'h30);
        chk("t_rsv_op",   32'(a_out_op),   32'd3);
        tick();

        // N_IN=5, DATA_W=4: LAT=3 with identity padding
        b_in_data = 20'hFFFF7; b_in_op = 2'b00; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        tick();
        chk("t4_b_early", 32'(b_out_valid), 32'd0);
        tick();
        chk("t4_b_and_valid", 32'(b_out_valid), 32'd1);
        chk("t4_b_and_data",  32'(b_out_data),  32'h7);
        b_in_data = 20'h00008; b_in_op = 2'b01; b_in_valid = 1'b1;
        tick();
        b_in_data = 20'h12345; b_in_op = 2'b10;
        tick();
        b_in_valid = 1'b0;
        tick();
        chk("t4_b_or_data", 32'(b_out_data), 32'h8);
        chk("t4_b_or_op",   32'(b_out_op),   32'd1);
        tick();
        chk("t4_b_xor_data", 32'(b_out_data), 32'h1);
        chk("t4_b_xor_op",   32'(b_out_op),   32'd2);
        tick();

        // N_IN=1: passthrough after one stage
        c_in_data = 8'hA5; c_in_op = 2'b00; c_in_valid = 1'b1;
        tick();
        c_in_data = 8'h3C; c_in_op = 2'b10;
        chk("t4_c_and_valid", 32'(c_out_valid), 32'd1);
        chk("t4_c_and_data",  32'(c_out_data),  32'hA5);
        tick();
        c_in_valid = 1'b0;
        chk("t4_c_xor_data", 32'(c_out_data), 32'h3C);
        chk("t4_c_xor_op",   32'(c_out_op),   32'd2);
        tick();
        chk("t4_c_drained", 32'(c_out_valid), 32'd0);

        // asynchronous reset with two in flight
        a_in_op = 2'b01; a_in_valid = 1'b1;
        tick();
        a_in_op = 2'b10;
        tick();
        a_in_valid = 1'b0;
        chk("t5_pre_valid", 32'(a_out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(a_out_valid), 32'd0);
        chk("t5_rst_data",  32'(a_out_data),  32'd0);
        chk("t5_rst_op",    32'(a_out_op),    32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_stale", 32'(a_out_valid), 32'd0);
        end
        a_in_op = 2'b00; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        chk("t5_next_valid", 32'(a_out_valid), 32'd1);
        chk("t5_next_data",  32'(a_out_data),  32'h30);
        tick();

`ifdef REDUCE_TREE_CNT_EN
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        chk("t6_cnt_rst", 32'(a_out_count), 32'd0);
        a_in_valid = 1'b1;
        repeat (10) tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        chk("t6_cnt_10", 32'(a_out_count), 32'd10);
        @(negedge clk);
        force u_a.cnt_q = 16'hFFFE;
        tick();
        release u_a.cnt_q;
        a_in_valid = 1'b1;
        repeat (3) tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        chk("t6_cnt_sat", 32'(a_out_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
